// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte out on device-generated clocks and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int DLY_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int DW      = $clog2(DLY_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [DW-1:0] INH_LAST = DW'(INHIBIT_CYCLES - 1);
    localparam logic [DW-1:0] REQ_LAST = DW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    // Index 0 = clock line, index 1 = data line.
    logic [1:0] pin_raw;
    logic [1:0] line_s;

    assign pin_raw = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] sync_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= 3'b111;
                end else begin
                    sync_reg <= {sync_reg[1:0], pin_raw[gi]};
                end
            end
            assign line_s[gi] = sync_reg[2];
        end
    endgenerate

    logic clk_s;
    logic data_s;
    logic clk_prev_reg;
    logic fall;

    assign clk_s  = line_s[0];
    assign data_s = line_s[1];
    assign fall   = clk_prev_reg & ~clk_s;

    state_t        state_reg,   state_next;
    logic [DW-1:0] dly_cnt_reg, dly_cnt_next;
    logic [TW-1:0] to_cnt_reg,  to_cnt_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg,   shift_next;
    logic          parity_reg,  parity_next;
    logic          ack_ok_reg,  ack_ok_next;
    logic          clk_oe_reg,  clk_oe_next;
    logic          data_oe_reg, data_oe_next;
    logic          busy_reg,    busy_next;
    logic          done_reg,    done_next;
    logic          error_reg,   error_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            dly_cnt_reg  <= '0;
            to_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            ack_ok_reg   <= 1'b0;
            clk_oe_reg   <= 1'b0;
            data_oe_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            error_reg    <= 1'b0;
            clk_prev_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            dly_cnt_reg  <= dly_cnt_next;
            to_cnt_reg   <= to_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            parity_reg   <= parity_next;
            ack_ok_reg   <= ack_ok_next;
            clk_oe_reg   <= clk_oe_next;
            data_oe_reg  <= data_oe_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            error_reg    <= error_next;
            clk_prev_reg <= clk_s;
        end
    end

    always_comb begin
        state_next   = state_reg;
        dly_cnt_next = dly_cnt_reg;
        to_cnt_next  = to_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        ack_ok_next  = ack_ok_reg;
        clk_oe_next  = clk_oe_reg;
        data_oe_next = data_oe_reg;
        done_next    = 1'b0;
        error_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                clk_oe_next  = 1'b0;
                data_oe_next = 1'b0;
                if (tx_start) begin
                    shift_next   = tx_data;
                    parity_next  = ~^tx_data;
                    dly_cnt_next = '0;
                    clk_oe_next  = 1'b1;
                    state_next   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (dly_cnt_reg == INH_LAST) begin
                    dly_cnt_next = '0;
                    data_oe_next = 1'b1;
                    state_next   = REQ;
                end else begin
                    dly_cnt_next = dly_cnt_reg + DW'(1);
                end
            end

            REQ: begin
                // The start bit (data low) stays driven into DATA until the first fall.
                if (dly_cnt_reg == REQ_LAST) begin
                    dly_cnt_next = '0;
                    clk_oe_next  = 1'b0;
                    bit_cnt_next = '0;
                    to_cnt_next  = '0;
                    state_next   = DATA;
                end else begin
                    dly_cnt_next = dly_cnt_reg + DW'(1);
                end
            end

            default: begin
                if (to_cnt_reg != TO_MAX) begin
                    to_cnt_next = to_cnt_reg + TW'(1);
                end
                // A timeout wins over any edge seen in the same cycle.
                if (to_cnt_reg >= TO_LAST) begin
                    clk_oe_next  = 1'b0;
                    data_oe_next = 1'b0;
                    error_next   = 1'b1;
                    state_next   = IDLE;
                end else begin
                    case (state_reg)
                        DATA: begin
                            if (fall) begin
                                bit_cnt_next = bit_cnt_reg + 4'd1;
                                if (bit_cnt_reg < 4'd8) begin
                                    data_oe_next = ~shift_reg[bit_cnt_reg[2:0]];
                                end else if (bit_cnt_reg == 4'd8) begin
                                    data_oe_next = ~parity_reg;
                                end else begin
                                    data_oe_next = 1'b0;
                                    state_next   = ACK;
                                end
                            end
                        end
                        ACK: begin
                            if (fall) begin
                                ack_ok_next = ~data_s;
                                state_next  = WAIT_IDLE;
                            end
                        end
                        WAIT_IDLE: begin
                            if (clk_s && data_s) begin
                                done_next  = ack_ok_reg;
                                error_next = ~ack_ok_reg;
                                state_next = IDLE;
                            end
                        end
                        default: begin
                            clk_oe_next  = 1'b0;
                            data_oe_next = 1'b0;
                            state_next   = IDLE;
                        end
                    endcase
                end
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign error       = error_reg;

endmodule
